// File: rtl/sm_dmem_arbiter_pkg.sv
// Shared types and defaults for the two-core data-memory arbiter.
package sm_dmem_arbiter_pkg;

  // Default width of the saturating statistics counters.
  localparam int unsigned SmArbCntW = 16;

  // Arbiter FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    SM_ARB_IDLE   = 2'd0,
    SM_ARB_SERVE0 = 2'd1,
    SM_ARB_SERVE1 = 2'd2
  } arbState_e;

  // Maps a port number onto the state that serves it.
  function automatic arbState_e serveState(input logic port);
    return port ? SM_ARB_SERVE1 : SM_ARB_SERVE0;
  endfunction

endpackage

// File: rtl/sm_dmem_arbiter_sat_counter.sv
// Saturating up-counter used for the arbiter's debug statistics.
module sm_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] count_q;

  // Count up on inc, holding at the all-ones value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign q = count_q;

endmodule

// File: rtl/sm_dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between two cores.
module sm_dmem_arbiter
  import sm_dmem_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W      = SmArbCntW,
  parameter int unsigned FIRST_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [31:0]      addr0,
  input  logic             we0,
  input  logic [31:0]      wdata0,
  output logic [31:0]      rdata0,
  output logic             ready0,
  input  logic             req1,
  input  logic [31:0]      addr1,
  input  logic             we1,
  input  logic [31:0]      wdata1,
  output logic [31:0]      rdata1,
  output logic             ready1,
  output logic [31:0]      mAddr,
  output logic             mWe,
  output logic [31:0]      mWData,
  input  logic [31:0]      mRData,
  output logic [CNT_W-1:0] accCnt0,
  output logic [CNT_W-1:0] accCnt1,
  output logic [CNT_W-1:0] waitCnt0,
  output logic [CNT_W-1:0] waitCnt1
);

  // Reset pretends the other port was granted last, so FIRST_PRIO wins first.
  localparam logic LastGrantRst = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  arbState_e state_q, state_d;
  logic      lastGrant_q, lastGrant_d;

  // State and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SM_ARB_IDLE;
      lastGrant_q <= LastGrantRst;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Next-state selection and memory/port muxing driven by the current state.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    mAddr       = '0;
    mWe         = 1'b0;
    mWData      = '0;
    ready0      = 1'b0;
    ready1      = 1'b0;
    rdata0      = '0;
    rdata1      = '0;
    case (state_q)
      SM_ARB_IDLE: begin
        if (req0 && req1) begin
          state_d = serveState(~lastGrant_q);
        end else if (req0) begin
          state_d = SM_ARB_SERVE0;
        end else if (req1) begin
          state_d = SM_ARB_SERVE1;
        end
      end
      SM_ARB_SERVE0: begin
        mAddr       = addr0;
        mWData      = wdata0;
        mWe         = we0 & req0;
        ready0      = 1'b1;
        rdata0      = mRData;
        lastGrant_d = 1'b0;
        if (req1) begin
          state_d = SM_ARB_SERVE1;
        end else if (req0) begin
          state_d = SM_ARB_SERVE0;
        end else begin
          state_d = SM_ARB_IDLE;
        end
      end
      SM_ARB_SERVE1: begin
        mAddr       = addr1;
        mWData      = wdata1;
        mWe         = we1 & req1;
        ready1      = 1'b1;
        rdata1      = mRData;
        lastGrant_d = 1'b1;
        if (req0) begin
          state_d = SM_ARB_SERVE0;
        end else if (req1) begin
          state_d = SM_ARB_SERVE1;
        end else begin
          state_d = SM_ARB_IDLE;
        end
      end
      default: begin
        state_d = SM_ARB_IDLE;
      end
    endcase
  end

  sm_sat_counter #(.W(CNT_W)) uAccCnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (req0 & ready0),
    .q     (accCnt0)
  );

  sm_sat_counter #(.W(CNT_W)) uAccCnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (req1 & ready1),
    .q     (accCnt1)
  );

  sm_sat_counter #(.W(CNT_W)) uWaitCnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (req0 & ~ready0),
    .q     (waitCnt0)
  );

  sm_sat_counter #(.W(CNT_W)) uWaitCnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (req1 & ~ready1),
    .q     (waitCnt1)
  );

endmodule

// File: tb/tb_sm_dmem_arbiter.sv
// Directed bench for sm_dmem_arbiter with a small behavioural RAM.
module tb_sm_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1;
  logic [31:0] mAddr, mWData, mRData;
  logic        mWe;
  logic [3:0]  accCnt0, accCnt1, waitCnt0, waitCnt1;

  logic [31:0] mem [0:63];
  int          writeCount;
  int          checks;
  int          failures;

  sm_dmem_arbiter #(.CNT_W(4), .FIRST_PRIO(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .addr0    (addr0),
    .we0      (we0),
    .wdata0   (wdata0),
    .rdata0   (rdata0),
    .ready0   (ready0),
    .req1     (req1),
    .addr1    (addr1),
    .we1      (we1),
    .wdata1   (wdata1),
    .rdata1   (rdata1),
    .ready1   (ready1),
    .mAddr    (mAddr),
    .mWe      (mWe),
    .mWData   (mWData),
    .mRData   (mRData),
    .accCnt0  (accCnt0),
    .accCnt1  (accCnt1),
    .waitCnt0 (waitCnt0),
    .waitCnt1 (waitCnt1)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word-indexed RAM model: asynchronous read, write on the clock edge.
  assign mRData = mem[mAddr[7:2]];

  always @(posedge clk) begin
    if (mWe) begin
      mem[mAddr[7:2]] <= mWData;
      writeCount      <= writeCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic r1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [15:0] counters;
  assign counters = {accCnt0, accCnt1, waitCnt0, waitCnt1};

  initial begin
    int run0, run1, wcSnap;
    logic [3:0] prevAcc;
    checks   = 0;
    failures = 0;
    writeCount = 0;

    // Reset then idle: nothing moves for 10 cycles.
    doReset();
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      #1;
      checkOutput("idle_rdy_we", {29'd0, ready0, ready1, mWe}, 32'd0);
      checkOutput("idle_cnt", {16'd0, counters}, 32'd0);
    end

    // Port 0 write then back-to-back read of the same address.
    doReset();
    nextCycle();
    applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    #1;
    checkOutput("wr0_wait_rdy", {31'd0, ready0}, 32'd0);
    nextCycle();
    #1;
    checkOutput("wr0_rdy", {31'd0, ready0}, 32'd1);
    checkOutput("wr0_mwe", {31'd0, mWe}, 32'd1);
    checkOutput("wr0_maddr", mAddr, 32'h10);
    nextCycle();
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
    #1;
    checkOutput("rd0_rdy", {31'd0, ready0}, 32'd1);
    checkOutput("rd0_mwe", {31'd0, mWe}, 32'd0);
    checkOutput("rd0_rdata", rdata0, 32'hDEADBEEF);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    #1;
    checkOutput("wr0rd0_cnt", {16'd0, counters}, {16'd0, 4'd2, 4'd0, 4'd1, 4'd0});
    checkOutput("wr0rd0_idle", {30'd0, ready0, ready1}, 32'd0);

    // Simultaneous contention straight after reset: port 0 first, then port 1.
    doReset();
    nextCycle();
    applyStimulus(1, 1, 32'h0, 32'h11111111, 1, 1, 32'h4, 32'h22222222);
    #1;
    checkOutput("cont_c0_rdy", {30'd0, ready0, ready1}, 32'd0);
    nextCycle();
    #1;
    checkOutput("cont_c1_rdy", {30'd0, ready0, ready1}, 32'b10);
    checkOutput("cont_c1_maddr", mAddr, 32'h0);
    checkOutput("cont_c1_rdata1", rdata1, 32'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h4, 32'h22222222);
    #1;
    checkOutput("cont_c2_rdy", {30'd0, ready0, ready1}, 32'b01);
    checkOutput("cont_c2_maddr", mAddr, 32'h4);
    checkOutput("cont_c2_mwe", {31'd0, mWe}, 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    checkOutput("cont_wait1", {28'd0, waitCnt1}, 32'd2);
    checkOutput("cont_ram0", mem[0], 32'h11111111);
    checkOutput("cont_ram1", mem[1], 32'h22222222);

    // Sustained contention: strict alternation and bounded waits.
    doReset();
    nextCycle();
    applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    run0 = 0;
    run1 = 0;
    for (int k = 0; k <= 20; k++) begin
      #1;
      if (k == 0) begin
        checkOutput("alt_c0", {30'd0, ready0, ready1}, 32'd0);
      end else begin
        checkOutput($sformatf("alt_c%0d", k), {30'd0, ready0, ready1},
                    (k % 2 == 1) ? 32'b10 : 32'b01);
      end
      run0 = ready0 ? 0 : run0 + 1;
      run1 = ready1 ? 0 : run1 + 1;
      checkOutput("alt_run0_le2", {31'd0, run0 <= 2}, 32'd1);
      checkOutput("alt_run1_le2", {31'd0, run1 <= 2}, 32'd1);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    checkOutput("alt_cnt", {16'd0, counters}, {16'd0, 4'd10, 4'd10, 4'd11, 4'd11});

    // Same-address race after a port-1 grant: port 0 then port 1 write.
    doReset();
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h8, 0);
    nextCycle();
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    applyStimulus(1, 1, 32'h20, 32'hAAAA0001, 1, 1, 32'h20, 32'hBBBB0002);
    #1;
    checkOutput("race_c0_rdy", {30'd0, ready0, ready1}, 32'd0);
    nextCycle();
    #1;
    checkOutput("race_c1_rdy", {30'd0, ready0, ready1}, 32'b10);
    checkOutput("race_c1_wdata", mWData, 32'hAAAA0001);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h20, 32'hBBBB0002);
    #1;
    checkOutput("race_c2_rdy", {30'd0, ready0, ready1}, 32'b01);
    checkOutput("race_c2_wdata", mWData, 32'hBBBB0002);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0);
    nextCycle();
    #1;
    checkOutput("race_rd_rdy", {31'd0, ready0}, 32'd1);
    checkOutput("race_rd_data", rdata0, 32'hBBBB0002);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();

    // Saturation: 20 back-to-back port-1 accesses on a 4-bit counter.
    doReset();
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h8, 0);
    prevAcc = 4'd0;
    for (int k = 0; k <= 20; k++) begin
      #1;
      checkOutput("sat_rdy1", {31'd0, ready1}, (k == 0) ? 32'd0 : 32'd1);
      checkOutput("sat_nowrap", {31'd0, accCnt1 >= prevAcc}, 32'd1);
      prevAcc = accCnt1;
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    checkOutput("sat_acc1", {28'd0, accCnt1}, 32'd15);
    checkOutput("sat_wait1", {28'd0, waitCnt1}, 32'd1);

    // Asynchronous reset in the middle of a write drops it.
    doReset();
    nextCycle();
    applyStimulus(1, 1, 32'h30, 32'h12345678, 0, 0, 0, 0);
    nextCycle();
    #1;
    checkOutput("arst_pre_mwe", {31'd0, mWe}, 32'd1);
    wcSnap = writeCount;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_rdy_we", {29'd0, ready0, ready1, mWe}, 32'd0);
    checkOutput("arst_maddr", mAddr, 32'h0);
    checkOutput("arst_mwdata", mWData, 32'h0);
    checkOutput("arst_cnt", {16'd0, counters}, 32'd0);
    nextCycle();
    checkOutput("arst_nowrite", writeCount, wcSnap);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
